// File: rtl/blink_tick_gen.sv
// Programmable tick generator: emits a one-cycle tick every P clocks, either
// for a burst of N ticks followed by a done pulse, or continuously until stopped.
module blink_tick_gen #(
    parameter int          CNT_W      = 24,
    parameter int          BURST_W    = 8,
    parameter int unsigned DEF_PERIOD = 12_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_count,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   period_q;
    logic [BURST_W-1:0] count_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BURST_W-1:0] tally_q;
    logic [CNT_W-1:0]   last_cnt;
    logic [BURST_W-1:0] tally_next;

    // A period of 0 behaves like 1; P-1 never underflows for P = 2^CNT_W-1.
    assign last_cnt   = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign tally_next = tally_q + BURST_W'(1);

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            period_q <= CNT_W'(DEF_PERIOD);
            count_q  <= '0;
            cnt_q    <= '0;
            tally_q  <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        period_q <= cfg_period;
                        count_q  <= cfg_count;
                    end
                    if (start && !stop) begin
                        state   <= RUN;
                        cnt_q   <= '0;
                        tally_q <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (cnt_q == last_cnt) begin
                        cnt_q   <= '0;
                        tick    <= 1'b1;
                        tally_q <= tally_next;
                        if (count_q != '0 && tally_next == count_q) begin
                            state <= FINISH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                FINISH: begin
                    // Two cycles here: the final tick drains, then done pulses alone.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
